// File: rtl/id_ex_operandos_pkg.sv
// Shared definitions for the ID/EX operand stage: ALU op codes, forwarding selects,
// and default datapath/register-index widths.
package id_ex_operandos_pkg;

    localparam int unsigned LARGURA_PAD   = 32;
    localparam int unsigned NBITS_REG_PAD = 5;
    localparam int unsigned REG_ZERO      = 0;

    typedef enum logic [1:0] {
        SEL_OP0 = 2'd0,
        SEL_OP1 = 2'd1,
        SEL_OP2 = 2'd2,
        SEL_OP3 = 2'd3
    } alu_sel_e;

    typedef enum logic [1:0] {
        FWD_REG   = 2'd0,
        FWD_EXMEM = 2'd1,
        FWD_MEMWB = 2'd2
    } fwd_sel_e;

endpackage

// File: rtl/id_ex_operandos_unidade_adiantamento.sv
// Forwarding unit for one source operand: picks EX/MEM, MEM/WB or the register-file value.
module unidade_adiantamento
    import id_ex_operandos_pkg::*;
#(
    parameter int unsigned NBITS_REG = NBITS_REG_PAD
) (
    input  logic [NBITS_REG-1:0] src_i,
    input  logic                 exmem_escreve_reg_i,
    input  logic [NBITS_REG-1:0] exmem_rd_i,
    input  logic                 memwb_escreve_reg_i,
    input  logic [NBITS_REG-1:0] memwb_rd_i,
    output fwd_sel_e             fwd_sel_o
);

    logic exmem_hit;
    logic memwb_hit;

    // $zero is hard-wired, so a write to index 0 is never a real producer.
    assign exmem_hit = exmem_escreve_reg_i && (exmem_rd_i != NBITS_REG'(REG_ZERO))
                       && (exmem_rd_i == src_i);
    assign memwb_hit = memwb_escreve_reg_i && (memwb_rd_i != NBITS_REG'(REG_ZERO))
                       && (memwb_rd_i == src_i);

    always_comb begin
        fwd_sel_o = FWD_REG;
        if (exmem_hit) begin
            fwd_sel_o = FWD_EXMEM;
        end else if (memwb_hit) begin
            fwd_sel_o = FWD_MEMWB;
        end
    end

endmodule

// File: rtl/id_ex_operandos.sv
// ID/EX pipeline register feeding the ALU, with EX/MEM and MEM/WB operand forwarding
// and an immediate select on operand B.
module id_ex_operandos
    import id_ex_operandos_pkg::*;
#(
    parameter int unsigned LARGURA   = LARGURA_PAD,
    parameter int unsigned NBITS_REG = NBITS_REG_PAD
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 stall,
    input  logic                 flush,
    input  logic                 in_valido,
    input  logic [LARGURA-1:0]   in_dadoA,
    input  logic [LARGURA-1:0]   in_dadoB,
    input  logic [LARGURA-1:0]   in_imediato,
    input  logic [NBITS_REG-1:0] in_rs,
    input  logic [NBITS_REG-1:0] in_rt,
    input  logic [NBITS_REG-1:0] in_rd,
    input  logic                 in_usaImediato,
    input  logic [1:0]           in_sel,
    input  logic                 in_escreveReg,
    input  logic                 exmem_escreveReg,
    input  logic [NBITS_REG-1:0] exmem_rd,
    input  logic [LARGURA-1:0]   exmem_resultado,
    input  logic                 memwb_escreveReg,
    input  logic [NBITS_REG-1:0] memwb_rd,
    input  logic [LARGURA-1:0]   memwb_resultado,
    output logic [LARGURA-1:0]   entradaA,
    output logic [LARGURA-1:0]   entradaB,
    output logic [1:0]           sel,
    output logic                 out_valido,
    output logic [NBITS_REG-1:0] out_rd,
    output logic                 out_escreveReg
);

    logic                 valido_q, valido_d;
    logic [LARGURA-1:0]   dado_a_q, dado_a_d;
    logic [LARGURA-1:0]   dado_b_q, dado_b_d;
    logic [LARGURA-1:0]   imediato_q, imediato_d;
    logic [NBITS_REG-1:0] rs_q, rs_d;
    logic [NBITS_REG-1:0] rt_q, rt_d;
    logic [NBITS_REG-1:0] rd_q, rd_d;
    logic                 usa_imediato_q, usa_imediato_d;
    logic [1:0]           sel_q, sel_d;
    logic                 escreve_reg_q, escreve_reg_d;

    fwd_sel_e             fwd_sel_a, fwd_sel_b;
    logic [LARGURA-1:0]   fwd_a, fwd_b;

    // flush beats stall: a squashed slot must not survive a concurrent hazard hold.
    always_comb begin
        valido_d       = valido_q;
        dado_a_d       = dado_a_q;
        dado_b_d       = dado_b_q;
        imediato_d     = imediato_q;
        rs_d           = rs_q;
        rt_d           = rt_q;
        rd_d           = rd_q;
        usa_imediato_d = usa_imediato_q;
        sel_d          = sel_q;
        escreve_reg_d  = escreve_reg_q;
        if (flush) begin
            valido_d       = 1'b0;
            dado_a_d       = '0;
            dado_b_d       = '0;
            imediato_d     = '0;
            rs_d           = '0;
            rt_d           = '0;
            rd_d           = '0;
            usa_imediato_d = 1'b0;
            sel_d          = SEL_OP0;
            escreve_reg_d  = 1'b0;
        end else if (!stall) begin
            valido_d       = in_valido;
            dado_a_d       = in_dadoA;
            dado_b_d       = in_dadoB;
            imediato_d     = in_imediato;
            rs_d           = in_rs;
            rt_d           = in_rt;
            rd_d           = in_rd;
            usa_imediato_d = in_usaImediato;
            sel_d          = in_sel;
            escreve_reg_d  = in_escreveReg;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valido_q       <= 1'b0;
            dado_a_q       <= '0;
            dado_b_q       <= '0;
            imediato_q     <= '0;
            rs_q           <= '0;
            rt_q           <= '0;
            rd_q           <= '0;
            usa_imediato_q <= 1'b0;
            sel_q          <= SEL_OP0;
            escreve_reg_q  <= 1'b0;
        end else begin
            valido_q       <= valido_d;
            dado_a_q       <= dado_a_d;
            dado_b_q       <= dado_b_d;
            imediato_q     <= imediato_d;
            rs_q           <= rs_d;
            rt_q           <= rt_d;
            rd_q           <= rd_d;
            usa_imediato_q <= usa_imediato_d;
            sel_q          <= sel_d;
            escreve_reg_q  <= escreve_reg_d;
        end
    end

    unidade_adiantamento #(
        .NBITS_REG (NBITS_REG)
    ) u_fwd_a (
        .src_i               (rs_q),
        .exmem_escreve_reg_i (exmem_escreveReg),
        .exmem_rd_i          (exmem_rd),
        .memwb_escreve_reg_i (memwb_escreveReg),
        .memwb_rd_i          (memwb_rd),
        .fwd_sel_o           (fwd_sel_a)
    );

    unidade_adiantamento #(
        .NBITS_REG (NBITS_REG)
    ) u_fwd_b (
        .src_i               (rt_q),
        .exmem_escreve_reg_i (exmem_escreveReg),
        .exmem_rd_i          (exmem_rd),
        .memwb_escreve_reg_i (memwb_escreveReg),
        .memwb_rd_i          (memwb_rd),
        .fwd_sel_o           (fwd_sel_b)
    );

    always_comb begin
        case (fwd_sel_a)
            FWD_EXMEM: fwd_a = exmem_resultado;
            FWD_MEMWB: fwd_a = memwb_resultado;
            default:   fwd_a = dado_a_q;
        endcase
    end

    always_comb begin
        case (fwd_sel_b)
            FWD_EXMEM: fwd_b = exmem_resultado;
            FWD_MEMWB: fwd_b = memwb_resultado;
            default:   fwd_b = dado_b_q;
        endcase
    end

    assign entradaA       = fwd_a;
    assign entradaB       = usa_imediato_q ? imediato_q : fwd_b;
    assign sel            = sel_q;
    assign out_valido     = valido_q;
    assign out_rd         = rd_q;
    assign out_escreveReg = escreve_reg_q & valido_q;

endmodule

// File: tb/tb_id_ex_operandos.sv
// Scoreboard bench for id_ex_operandos: expectations queued with stimulus, popped at sampling.
module tb_id_ex_operandos;

    logic        clk;
    logic        rst_n;
    logic        stall, flush;
    logic        in_valido;
    logic [31:0] in_dadoA, in_dadoB, in_imediato;
    logic [4:0]  in_rs, in_rt, in_rd;
    logic        in_usaImediato;
    logic [1:0]  in_sel;
    logic        in_escreveReg;
    logic        exmem_escreveReg;
    logic [4:0]  exmem_rd;
    logic [31:0] exmem_resultado;
    logic        memwb_escreveReg;
    logic [4:0]  memwb_rd;
    logic [31:0] memwb_resultado;
    logic [31:0] entradaA, entradaB;
    logic [1:0]  sel;
    logic        out_valido;
    logic [4:0]  out_rd;
    logic        out_escreveReg;

    typedef struct packed {
        logic [31:0] a;
        logic [31:0] b;
        logic [1:0]  sel;
        logic        v;
        logic        w;
        logic [4:0]  rd;
    } obs_t;

    obs_t q[$];
    obs_t got, e;
    int   total;
    int   bad;

    id_ex_operandos dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .stall            (stall),
        .flush            (flush),
        .in_valido        (in_valido),
        .in_dadoA         (in_dadoA),
        .in_dadoB         (in_dadoB),
        .in_imediato      (in_imediato),
        .in_rs            (in_rs),
        .in_rt            (in_rt),
        .in_rd            (in_rd),
        .in_usaImediato   (in_usaImediato),
        .in_sel           (in_sel),
        .in_escreveReg    (in_escreveReg),
        .exmem_escreveReg (exmem_escreveReg),
        .exmem_rd         (exmem_rd),
        .exmem_resultado  (exmem_resultado),
        .memwb_escreveReg (memwb_escreveReg),
        .memwb_rd         (memwb_rd),
        .memwb_resultado  (memwb_resultado),
        .entradaA         (entradaA),
        .entradaB         (entradaB),
        .sel              (sel),
        .out_valido       (out_valido),
        .out_rd           (out_rd),
        .out_escreveReg   (out_escreveReg)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic obs_t sample();
        obs_t o;
        o.a   = entradaA;
        o.b   = entradaB;
        o.sel = sel;
        o.v   = out_valido;
        o.w   = out_escreveReg;
        o.rd  = out_rd;
        return o;
    endfunction

    function automatic obs_t mk(input logic [31:0] a, input logic [31:0] b, input logic [1:0] s,
                                input logic v, input logic w, input logic [4:0] rd);
        obs_t o;
        o.a = a; o.b = b; o.sel = s; o.v = v; o.w = w; o.rd = rd;
        return o;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] imm, input logic [4:0] rs, input logic [4:0] rt,
                         input logic [4:0] rd, input logic usa, input logic [1:0] s,
                         input logic w);
        in_valido = v; in_dadoA = a; in_dadoB = b; in_imediato = imm;
        in_rs = rs; in_rt = rt; in_rd = rd; in_usaImediato = usa; in_sel = s;
        in_escreveReg = w;
    endtask

    task automatic fwd_idle();
        exmem_escreveReg = 1'b0; exmem_rd = '0; exmem_resultado = '0;
        memwb_escreveReg = 1'b0; memwb_rd = '0; memwb_resultado = '0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; stall = 1'b0; flush = 1'b0;
        drive(1'b1, 32'd11, 32'd22, 32'd33, 5'd1, 5'd2, 5'd3, 1'b0, 2'd2, 1'b1);
        fwd_idle();
        q.push_back(mk(32'd0, 32'd0, 2'd0, 1'b0, 1'b0, 5'd0));
        step();
        step();
        e = q.pop_front(); got = sample(); total++;
        if (got !== e) begin bad++; $display("FAIL reset got=%h exp=%h", got, e); end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_load();
        exmem_escreveReg = 1'b1; exmem_rd = 5'd10; exmem_resultado = 32'd111;
        memwb_escreveReg = 1'b1; memwb_rd = 5'd11; memwb_resultado = 32'd222;
        drive(1'b1, 32'd5001, 32'd3001, 32'd9, 5'd1, 5'd2, 5'd7, 1'b0, 2'd1, 1'b1);
        q.push_back(mk(32'd5001, 32'd3001, 2'd1, 1'b1, 1'b1, 5'd7));
        step();
        e = q.pop_front(); got = sample(); total++;
        if (got !== e) begin bad++; $display("FAIL load got=%h exp=%h", got, e); end
        // bubble with escreveReg set: write enable must be masked, data still driven
        drive(1'b0, 32'd42, 32'd43, 32'd0, 5'd4, 5'd5, 5'd6, 1'b0, 2'd3, 1'b1);
        q.push_back(mk(32'd42, 32'd43, 2'd3, 1'b0, 1'b0, 5'd6));
        step();
        e = q.pop_front(); got = sample(); total++;
        if (got !== e) begin bad++; $display("FAIL bubble got=%h exp=%h", got, e); end
        fwd_idle();
    endtask

    task automatic test_fwd_a();
        drive(1'b1, 32'd1234, 32'd2222, 32'd0, 5'd3, 5'd4, 5'd8, 1'b0, 2'd2, 1'b1);
        step();
        exmem_escreveReg = 1'b1; exmem_rd = 5'd3; exmem_resultado = 32'd8006001;
        memwb_escreveReg = 1'b1; memwb_rd = 5'd3; memwb_resultado = 32'd77;
        q.push_back(mk(32'd8006001, 32'd2222, 2'd2, 1'b1, 1'b1, 5'd8));
        #1;
        e = q.pop_front(); got = sample(); total++;
        if (got !== e) begin bad++; $display("FAIL fwd_exmem_prio got=%h exp=%h", got, e); end
        exmem_escreveReg = 1'b0;
        q.push_back(mk(32'd77, 32'd2222, 2'd2, 1'b1, 1'b1, 5'd8));
        #1;
        e = q.pop_front(); got = sample(); total++;
        if (got !== e) begin bad++; $display("FAIL fwd_memwb got=%h exp=%h", got, e); end
        memwb_rd = 5'd4;
        q.push_back(mk(32'd1234, 32'd77, 2'd2, 1'b1, 1'b1, 5'd8));
        #1;
        e = q.pop_front(); got = sample(); total++;
        if (got !== e) begin bad++; $display("FAIL fwd_b_memwb got=%h exp=%h", got, e); end
        memwb_escreveReg = 1'b0;
        q.push_back(mk(32'd1234, 32'd2222, 2'd2, 1'b1, 1'b1, 5'd8));
        #1;
        e = q.pop_front(); got = sample(); total++;
        if (got !== e) begin bad++; $display("FAIL fwd_none got=%h exp=%h", got, e); end
        fwd_idle();
    endtask

    task automatic test_fwd_b();
        drive(1'b1, 32'd321, 32'd4444, 32'd0, 5'd0, 5'd0, 5'd12, 1'b0, 2'd0, 1'b1);
        step();
        exmem_escreveReg = 1'b1; exmem_rd = 5'd0; exmem_resultado = 32'd99;
        memwb_escreveReg = 1'b1; memwb_rd = 5'd0; memwb_resultado = 32'd98;
        q.push_back(mk(32'd321, 32'd4444, 2'd0, 1'b1, 1'b1, 5'd12));
        #1;
        e = q.pop_front(); got = sample(); total++;
        if (got !== e) begin bad++; $display("FAIL zero_no_fwd got=%h exp=%h", got, e); end
        exmem_rd = 5'd5;
        drive(1'b1, 32'd1, 32'd2, 32'd8002, 5'd6, 5'd5, 5'd13, 1'b1, 2'd3, 1'b0);
        q.push_back(mk(32'd1, 32'd8002, 2'd3, 1'b1, 1'b0, 5'd13));
        step();
        e = q.pop_front(); got = sample(); total++;
        if (got !== e) begin bad++; $display("FAIL imm_prio got=%h exp=%h", got, e); end
        fwd_idle();
    endtask

    task automatic test_stall();
        drive(1'b1, 32'd100, 32'd200, 32'd0, 5'd6, 5'd7, 5'd9, 1'b0, 2'd3, 1'b1);
        q.push_back(mk(32'd100, 32'd200, 2'd3, 1'b1, 1'b1, 5'd9));
        step();
        e = q.pop_front(); got = sample(); total++;
        if (got !== e) begin bad++; $display("FAIL stall_pre got=%h exp=%h", got, e); end
        stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            drive(1'b0, 32'd900 + i, 32'd800 + i, 32'd700, 5'd20, 5'd21, 5'd22, 1'b1, 2'd1,
                  1'b0);
            q.push_back(mk(32'd100, 32'd200, 2'd3, 1'b1, 1'b1, 5'd9));
            step();
            e = q.pop_front(); got = sample(); total++;
            if (got !== e) begin bad++; $display("FAIL stall_hold%0d got=%h exp=%h", i, got, e); end
        end
        exmem_escreveReg = 1'b1; exmem_rd = 5'd6; exmem_resultado = 32'd555;
        q.push_back(mk(32'd555, 32'd200, 2'd3, 1'b1, 1'b1, 5'd9));
        #1;
        e = q.pop_front(); got = sample(); total++;
        if (got !== e) begin bad++; $display("FAIL stall_fwd got=%h exp=%h", got, e); end
        exmem_resultado = 32'd556;
        q.push_back(mk(32'd556, 32'd200, 2'd3, 1'b1, 1'b1, 5'd9));
        step();
        e = q.pop_front(); got = sample(); total++;
        if (got !== e) begin bad++; $display("FAIL stall_track got=%h exp=%h", got, e); end
        stall = 1'b0;
        fwd_idle();
    endtask

    task automatic test_flush();
        drive(1'b1, 32'd61, 32'd62, 32'd63, 5'd14, 5'd15, 5'd16, 1'b1, 2'd2, 1'b1);
        step();
        stall = 1'b1; flush = 1'b1;
        q.push_back(mk(32'd0, 32'd0, 2'd0, 1'b0, 1'b0, 5'd0));
        step();
        e = q.pop_front(); got = sample(); total++;
        if (got !== e) begin bad++; $display("FAIL flush_stall got=%h exp=%h", got, e); end
        stall = 1'b0; flush = 1'b0;
        drive(1'b1, 32'd71, 32'd72, 32'd0, 5'd17, 5'd18, 5'd19, 1'b0, 2'd1, 1'b1);
        q.push_back(mk(32'd71, 32'd72, 2'd1, 1'b1, 1'b1, 5'd19));
        step();
        e = q.pop_front(); got = sample(); total++;
        if (got !== e) begin bad++; $display("FAIL flush_resume got=%h exp=%h", got, e); end
    endtask

    task automatic test_async_reset();
        drive(1'b1, 32'd81, 32'd82, 32'd0, 5'd1, 5'd2, 5'd23, 1'b0, 2'd3, 1'b1);
        step();
        rst_n = 1'b0;
        q.push_back(mk(32'd0, 32'd0, 2'd0, 1'b0, 1'b0, 5'd0));
        #1;
        e = q.pop_front(); got = sample(); total++;
        if (got !== e) begin bad++; $display("FAIL async_reset got=%h exp=%h", got, e); end
        q.push_back(mk(32'd0, 32'd0, 2'd0, 1'b0, 1'b0, 5'd0));
        step();
        e = q.pop_front(); got = sample(); total++;
        if (got !== e) begin bad++; $display("FAIL reset_held got=%h exp=%h", got, e); end
        @(negedge clk);
        rst_n = 1'b1;
        q.push_back(mk(32'd81, 32'd82, 2'd3, 1'b1, 1'b1, 5'd23));
        step();
        e = q.pop_front(); got = sample(); total++;
        if (got !== e) begin bad++; $display("FAIL reset_release got=%h exp=%h", got, e); end
    endtask

    initial begin
        total = 0;
        bad   = 0;
        test_reset();
        test_load();
        test_fwd_a();
        test_fwd_b();
        test_stall();
        test_flush();
        test_async_reset();
        total++;
        if (q.size() != 0) begin
            bad++;
            $display("FAIL scoreboard_drain got=%0d exp=0", q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
